// File: rtl/mc_control_unit_if.sv
// rtl/mc_control_unit_if.sv - instruction decode inputs and datapath control outputs of the multicycle control unit
interface mc_control_unit_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       overflow;
  logic       PCWrite;
  logic       MemWrite;
  logic [1:0] IorD;
  logic       IRWrite;
  logic       RegWrite;
  logic       RegDst;
  logic       MemToReg;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUOp;
  logic [1:0] PCSource;
  logic       EPCWrite;
  logic [4:0] state;

  // control unit side
  modport master (
    input  opcode, funct, zero, overflow,
    output PCWrite, MemWrite, IorD, IRWrite, RegWrite, RegDst, MemToReg,
           ALUSrcA, ALUSrcB, ALUOp, PCSource, EPCWrite, state
  );

  // datapath side
  modport slave (
    output opcode, funct, zero, overflow,
    input  PCWrite, MemWrite, IorD, IRWrite, RegWrite, RegDst, MemToReg,
           ALUSrcA, ALUSrcB, ALUOp, PCSource, EPCWrite, state
  );
endinterface

// File: rtl/mc_control_unit.sv
// rtl/mc_control_unit.sv - Moore multicycle CPU control FSM; OVF_TRAP_EN enables overflow traps on add/sub/addi writeback
module mc_control_unit #(
  parameter int unsigned MEM_WAIT = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  mc_control_unit_if.master     bus
);

  typedef enum logic [4:0] {
    S_RST = 5'd0,  S_F0  = 5'd1,  S_FW  = 5'd2,  S_F2  = 5'd3,
    S_DEC = 5'd4,  S_EXR = 5'd5,  S_WBR = 5'd6,  S_EXI = 5'd7,
    S_WBI = 5'd8,  S_MA  = 5'd9,  S_MR0 = 5'd10, S_MRW = 5'd11,
    S_MWB = 5'd12, S_MW  = 5'd13, S_BR  = 5'd14, S_JMP = 5'd15,
    S_EXC = 5'd16
  } state_t;

  // R-type operation captured at decode so later states ignore IR changes
  localparam logic [1:0] ROP_ADD = 2'd0;
  localparam logic [1:0] ROP_SUB = 2'd1;
  localparam logic [1:0] ROP_AND = 2'd2;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;

  // last wait-counter value before leaving FW/MRW
  localparam logic [1:0] WAIT_LAST = 2'((MEM_WAIT == 0) ? 0 : MEM_WAIT - 1);

  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       is_sw_q, is_sw_d;
  logic [1:0] rop_q, rop_d;

`ifndef OVF_TRAP_EN
  logic unused_overflow;
  assign unused_overflow = bus.overflow;
`endif

  // state, wait counter and decoded-instruction registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_RST;
      cnt_q   <= 2'd0;
      is_sw_q <= 1'b0;
      rop_q   <= ROP_ADD;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      is_sw_q <= is_sw_d;
      rop_q   <= rop_d;
    end
  end

  // next state and state-decoded datapath controls
  always_comb begin
    state_d      = S_RST;
    cnt_d        = cnt_q;
    is_sw_d      = is_sw_q;
    rop_d        = rop_q;
    bus.PCWrite  = 1'b0;
    bus.MemWrite = 1'b0;
    bus.IorD     = 2'd0;
    bus.IRWrite  = 1'b0;
    bus.RegWrite = 1'b0;
    bus.RegDst   = 1'b0;
    bus.MemToReg = 1'b0;
    bus.ALUSrcA  = 1'b0;
    bus.ALUSrcB  = 2'd0;
    bus.ALUOp    = ALU_PASS;
    bus.PCSource = 2'd0;
    bus.EPCWrite = 1'b0;
    bus.state    = state_q;

    case (state_q)
      S_RST: state_d = S_F0;
      S_F0: begin
        bus.IorD = 2'd0;
        cnt_d    = 2'd0;
        state_d  = (MEM_WAIT == 0) ? S_F2 : S_FW;
      end
      S_FW: begin
        if (cnt_q == WAIT_LAST) state_d = S_F2;
        else begin
          state_d = S_FW;
          cnt_d   = cnt_q + 2'd1;
        end
      end
      S_F2: begin
        bus.IRWrite = 1'b1;
        bus.ALUSrcB = 2'd1;
        bus.ALUOp   = ALU_ADD;
        bus.PCWrite = 1'b1;
        state_d     = S_DEC;
      end
      S_DEC: begin
        bus.ALUSrcB = 2'd3;
        bus.ALUOp   = ALU_ADD;
        case (bus.opcode)
          6'h00: begin
            case (bus.funct)
              6'h20:   begin state_d = S_EXR; rop_d = ROP_ADD; end
              6'h22:   begin state_d = S_EXR; rop_d = ROP_SUB; end
              6'h24:   begin state_d = S_EXR; rop_d = ROP_AND; end
              default: state_d = S_EXC;
            endcase
          end
          6'h08:   state_d = S_EXI;
          6'h23:   begin state_d = S_MA; is_sw_d = 1'b0; end
          6'h2B:   begin state_d = S_MA; is_sw_d = 1'b1; end
          6'h04:   state_d = S_BR;
          6'h02:   state_d = S_JMP;
          default: state_d = S_EXC;
        endcase
      end
      S_EXR: begin
        bus.ALUSrcA = 1'b1;
        case (rop_q)
          ROP_SUB: bus.ALUOp = ALU_SUB;
          ROP_AND: bus.ALUOp = ALU_AND;
          default: bus.ALUOp = ALU_ADD;
        endcase
        state_d = S_WBR;
      end
      S_WBR: begin
        bus.RegDst   = 1'b1;
        bus.RegWrite = 1'b1;
        state_d      = S_F0;
`ifdef OVF_TRAP_EN
        if (bus.overflow && (rop_q != ROP_AND)) begin
          bus.RegWrite = 1'b0;
          state_d      = S_EXC;
        end
`endif
      end
      S_EXI: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'd2;
        bus.ALUOp   = ALU_ADD;
        state_d     = S_WBI;
      end
      S_WBI: begin
        bus.RegWrite = 1'b1;
        state_d      = S_F0;
`ifdef OVF_TRAP_EN
        if (bus.overflow) begin
          bus.RegWrite = 1'b0;
          state_d      = S_EXC;
        end
`endif
      end
      S_MA: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'd2;
        bus.ALUOp   = ALU_ADD;
        state_d     = is_sw_q ? S_MW : S_MR0;
      end
      S_MR0: begin
        bus.IorD = 2'd1;
        cnt_d    = 2'd0;
        state_d  = (MEM_WAIT == 0) ? S_MWB : S_MRW;
      end
      S_MRW: begin
        if (cnt_q == WAIT_LAST) state_d = S_MWB;
        else begin
          state_d = S_MRW;
          cnt_d   = cnt_q + 2'd1;
        end
      end
      S_MWB: begin
        bus.MemToReg = 1'b1;
        bus.RegWrite = 1'b1;
        state_d      = S_F0;
      end
      S_MW: begin
        bus.IorD     = 2'd1;
        bus.MemWrite = 1'b1;
        state_d      = S_F0;
      end
      S_BR: begin
        bus.ALUSrcA  = 1'b1;
        bus.ALUOp    = ALU_SUB;
        bus.PCSource = 2'd1;
        bus.PCWrite  = bus.zero;
        state_d      = S_F0;
      end
      S_JMP: begin
        bus.PCSource = 2'd2;
        bus.PCWrite  = 1'b1;
        state_d      = S_F0;
      end
      S_EXC: begin
        bus.PCSource = 2'd3;
        bus.PCWrite  = 1'b1;
        bus.EPCWrite = 1'b1;
        state_d      = S_F0;
      end
      default: state_d = S_RST;
    endcase
  end

endmodule

// File: tb/tb_mc_control_unit.sv
// tb/tb_mc_control_unit.sv - scoreboard bench for mc_control_unit with MEM_WAIT=1
module tb_mc_control_unit;
  logic clock = 1'b0;
  logic reset = 1'b0;

  mc_control_unit_if bus ();

  mc_control_unit #(.MEM_WAIT(1)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  logic [21:0] exp_q[$];
  string       tag_q[$];
  int          n_cmp  = 0;
  int          n_fail = 0;
  int          n_steps = 0;

  // {state, PCWrite, MemWrite, IorD, IRWrite, RegWrite, RegDst, MemToReg, ALUSrcA, ALUSrcB, ALUOp, PCSource, EPCWrite}
  function automatic logic [21:0] ex(input logic [4:0] st, input logic pcw, input logic memw,
                                     input logic [1:0] iord, input logic irw, input logic regw,
                                     input logic regdst, input logic m2r, input logic srca,
                                     input logic [1:0] srcb, input logic [2:0] aluop,
                                     input logic [1:0] pcsrc, input logic epcw);
    return {st, pcw, memw, iord, irw, regw, regdst, m2r, srca, srcb, aluop, pcsrc, epcw};
  endfunction

  function automatic logic [21:0] obs();
    return {bus.state, bus.PCWrite, bus.MemWrite, bus.IorD, bus.IRWrite, bus.RegWrite,
            bus.RegDst, bus.MemToReg, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.PCSource,
            bus.EPCWrite};
  endfunction

  task automatic check(input string tag, input logic [21:0] o, input logic [21:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic push(input string tag, input logic [21:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic push_fetch(input string n);
    push({n, ".F0"},  ex(5'd1, 0,0,2'd0,0,0,0,0,0,2'd0,3'b000,2'd0,0));
    push({n, ".FW"},  ex(5'd2, 0,0,2'd0,0,0,0,0,0,2'd0,3'b000,2'd0,0));
    push({n, ".F2"},  ex(5'd3, 1,0,2'd0,1,0,0,0,0,2'd1,3'b001,2'd0,0));
    push({n, ".DEC"}, ex(5'd4, 0,0,2'd0,0,0,0,0,0,2'd3,3'b001,2'd0,0));
  endtask

  task automatic push_exc(input string n);
    push({n, ".EXC"}, ex(5'd16, 1,0,2'd0,0,0,0,0,0,2'd0,3'b000,2'd3,1));
  endtask

  // compare k scoreboard entries, one per clock
  task automatic drain(input int k);
    for (int i = 0; i < k && exp_q.size() > 0; i++) begin
      check(tag_q.pop_front(), obs(), exp_q.pop_front());
      @(negedge clock);
      n_steps++;
    end
  endtask

  // drain remaining entries, then require a return to F0 within a bound and the inclusive F0..F0 latency
  task automatic finish_instr(input string n, input int lat);
    int guard;
    drain(exp_q.size());
    guard = 0;
    while (bus.state !== 5'd1 && guard < 20) begin
      @(negedge clock);
      n_steps++;
      guard++;
    end
    check({n, ".back_to_F0"}, 22'(bus.state), 22'd1);
    check({n, ".latency"}, 22'(n_steps + 1), 22'(lat));
    n_steps = 0;
  endtask

  initial begin
    bus.opcode   = 6'h00;
    bus.funct    = 6'h22;
    bus.zero     = 1'b0;
    bus.overflow = 1'b0;

    // reset held low for 3 cycles
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("reset.hold", obs(), 22'd0);
    end
    reset = 1'b1;
    #1;
    check("reset.release", obs(), 22'd0);
    @(negedge clock);
    check("reset.to_F0", 22'(bus.state), 22'd1);
    n_steps = 0;

    // R-type sub
    bus.opcode = 6'h00; bus.funct = 6'h22;
    push_fetch("sub");
    push("sub.EXR", ex(5'd5, 0,0,2'd0,0,0,0,0,1,2'd0,3'b010,2'd0,0));
    push("sub.WBR", ex(5'd6, 0,0,2'd0,0,1,1,0,0,2'd0,3'b000,2'd0,0));
    finish_instr("sub", 7);

    // R-type add
    bus.funct = 6'h20;
    push_fetch("add");
    push("add.EXR", ex(5'd5, 0,0,2'd0,0,0,0,0,1,2'd0,3'b001,2'd0,0));
    push("add.WBR", ex(5'd6, 0,0,2'd0,0,1,1,0,0,2'd0,3'b000,2'd0,0));
    finish_instr("add", 7);

    // R-type and, overflow high never traps
    bus.funct = 6'h24; bus.overflow = 1'b1;
    push_fetch("and");
    push("and.EXR", ex(5'd5, 0,0,2'd0,0,0,0,0,1,2'd0,3'b011,2'd0,0));
    push("and.WBR", ex(5'd6, 0,0,2'd0,0,1,1,0,0,2'd0,3'b000,2'd0,0));
    finish_instr("and", 7);
    bus.overflow = 1'b0;

    // addi
    bus.opcode = 6'h08;
    push_fetch("addi");
    push("addi.EXI", ex(5'd7, 0,0,2'd0,0,0,0,0,1,2'd2,3'b001,2'd0,0));
    push("addi.WBI", ex(5'd8, 0,0,2'd0,0,1,0,0,0,2'd0,3'b000,2'd0,0));
    finish_instr("addi", 7);

    // addi with overflow
    bus.overflow = 1'b1;
    push_fetch("addi_ovf");
    push("addi_ovf.EXI", ex(5'd7, 0,0,2'd0,0,0,0,0,1,2'd2,3'b001,2'd0,0));
`ifdef OVF_TRAP_EN
    push("addi_ovf.WBI", ex(5'd8, 0,0,2'd0,0,0,0,0,0,2'd0,3'b000,2'd0,0));
    push_exc("addi_ovf");
    finish_instr("addi_ovf", 8);
`else
    push("addi_ovf.WBI", ex(5'd8, 0,0,2'd0,0,1,0,0,0,2'd0,3'b000,2'd0,0));
    finish_instr("addi_ovf", 7);
`endif
    bus.overflow = 1'b0;

    // lw
    bus.opcode = 6'h23;
    push_fetch("lw");
    push("lw.MA",  ex(5'd9,  0,0,2'd0,0,0,0,0,1,2'd2,3'b001,2'd0,0));
    push("lw.MR0", ex(5'd10, 0,0,2'd1,0,0,0,0,0,2'd0,3'b000,2'd0,0));
    push("lw.MRW", ex(5'd11, 0,0,2'd0,0,0,0,0,0,2'd0,3'b000,2'd0,0));
    push("lw.MWB", ex(5'd12, 0,0,2'd0,0,1,0,1,0,2'd0,3'b000,2'd0,0));
    finish_instr("lw", 9);

    // sw; opcode rewritten after decode must not redirect it
    bus.opcode = 6'h2B;
    push_fetch("sw");
    push("sw.MA", ex(5'd9,  0,0,2'd0,0,0,0,0,1,2'd2,3'b001,2'd0,0));
    push("sw.MW", ex(5'd13, 0,1,2'd1,0,0,0,0,0,2'd0,3'b000,2'd0,0));
    drain(4);
    bus.opcode = 6'h23;
    finish_instr("sw", 7);
    check("sw.single_strobe", 22'(bus.MemWrite), 22'd0);

    // beq taken
    bus.opcode = 6'h04; bus.zero = 1'b1;
    push_fetch("beq_t");
    push("beq_t.BR", ex(5'd14, 1,0,2'd0,0,0,0,0,1,2'd0,3'b010,2'd1,0));
    finish_instr("beq_t", 6);

    // beq not taken
    bus.zero = 1'b0;
    push_fetch("beq_n");
    push("beq_n.BR", ex(5'd14, 0,0,2'd0,0,0,0,0,1,2'd0,3'b010,2'd1,0));
    finish_instr("beq_n", 6);

    // jump
    bus.opcode = 6'h02;
    push_fetch("j");
    push("j.JMP", ex(5'd15, 1,0,2'd0,0,0,0,0,0,2'd0,3'b000,2'd2,0));
    finish_instr("j", 6);

    // illegal opcode
    bus.opcode = 6'h3F;
    push_fetch("ill_op");
    push_exc("ill_op");
    finish_instr("ill_op", 6);

    // illegal funct
    bus.opcode = 6'h00; bus.funct = 6'h27;
    push_fetch("ill_fn");
    push_exc("ill_fn");
    finish_instr("ill_fn", 6);

    // asynchronous reset while in MW
    bus.opcode = 6'h2B;
    push_fetch("sw_rst");
    push("sw_rst.MA", ex(5'd9,  0,0,2'd0,0,0,0,0,1,2'd2,3'b001,2'd0,0));
    push("sw_rst.MW", ex(5'd13, 0,1,2'd1,0,0,0,0,0,2'd0,3'b000,2'd0,0));
    drain(5);
    check("sw_rst.in_MW", 22'(bus.MemWrite), 22'd1);
    exp_q.delete();
    tag_q.delete();
    reset = 1'b0;
    #1;
    check("sw_rst.immediate", obs(), 22'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("sw_rst.restart_F0", 22'(bus.state), 22'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // absolute time bound
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
- Moore-style multicycle control FSM for the CPU datapath.
- Sits directly upstream of the PC register and memory in the cpu top. Drives PCWrite, MemWrite, IorD, PCSource and the remaining datapath selects.
- Decodes opcode/funct from the instruction register and sequences fetch, decode, execute, memory and writeback states.
- Handles branch resolution and an illegal-instruction exception path.

Parameters:
- MEM_WAIT, 1, extra wait cycles between memory address presentation and valid data (0..3).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- opcode  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag.
- overflow  in  1  ALU signed-overflow flag.
- PCWrite  out  1  PC load; already qualified with zero on branches.
- MemWrite  out  1  memory write strobe.
- IorD  out  2  address select: 0=PC, 1=ALUOut, 2/3 reserved (never driven).
- IRWrite  out  1  instruction register load.
- RegWrite  out  1  register file write.
- RegDst  out  1  0=rt, 1=rd.
- MemToReg  out  1  0=ALUOut, 1=MDR.
- ALUSrcA  out  1  0=PC, 1=A.
- ALUSrcB  out  2  0=B, 1=const 4, 2=sext(imm), 3=sext(imm)<<2.
- ALUOp  out  3  001=add, 010=sub, 011=and, 000=pass A.
- PCSource  out  2  0=ALU result, 1=ALUOut, 2=jump target, 3=exception vector 0x000000FC.
- EPCWrite  out  1  load EPC with PC-4.
- state  out  5  current state code, debug.

Behaviour:
- Reset (reset=0, async): state=RST. All outputs are 0 while in RST.
- After reset release, RST lasts one clock, then the FSM enters F0.
- Every output is a function of state only, except PCWrite in BR = zero.
- Unlisted outputs are 0 in each state.
- State codes and actions:
  - RST=0.
  - F0=1: IorD=0, memory read address = PC.
  - FW=2: wait state; repeated MEM_WAIT times (counter). With MEM_WAIT=0 it is skipped.
  - F2=3: IRWrite=1, ALUSrcA=0, ALUSrcB=1, ALUOp=add, PCSource=0, PCWrite=1.
  - DEC=4: ALUSrcA=0, ALUSrcB=3, ALUOp=add (branch target into ALUOut). Dispatches on opcode.
  - EXR=5: ALUSrcA=1, ALUSrcB=0, ALUOp by funct: 0x20 add, 0x22 sub, 0x24 and.
  - WBR=6: RegDst=1, MemToReg=0, RegWrite=1.
  - EXI=7: ALUSrcA=1, ALUSrcB=2, ALUOp=add.
  - WBI=8: RegDst=0, RegWrite=1.
  - MA=9: ALUSrcA=1, ALUSrcB=2, ALUOp=add.
  - MR0=10: IorD=1.
  - MRW=11: wait, MEM_WAIT times.
  - MWB=12: MemToReg=1, RegDst=0, RegWrite=1.
  - MW=13: IorD=1, MemWrite=1 for exactly one cycle.
  - BR=14: ALUSrcA=1, ALUSrcB=0, ALUOp=sub, PCSource=1, PCWrite=zero.
  - JMP=15: PCSource=2, PCWrite=1.
  - EXC=16: PCSource=3, PCWrite=1, EPCWrite=1.
- DEC dispatch:
  - 0x00: EXR if funct is in {0x20,0x22,0x24}, else EXC.
  - 0x08 addi: EXI.
  - 0x23 lw / 0x2B sw: MA.
  - 0x04 beq: BR.
  - 0x02 j: JMP.
  - Any other opcode: EXC.
- MA goes to MR0 for lw, MW for sw.
- Fixed successors: EXR→WBR, EXI→WBI, MR0→MRW/MWB.
- WBR, WBI, MWB, MW, BR, JMP and EXC all return to F0.
- Latencies with MEM_WAIT=1: R-type 7, addi 7, lw 9, sw 7, beq 6, j 6 cycles, F0 to next F0.
- Wait counter: 2 bits, cleared on entry to FW/MRW; exits when count = MEM_WAIT-1.
- opcode/funct are sampled only in DEC and EXR. Changes at any other time are ignored.
- Async reset mid-instruction: immediate RST, MemWrite/PCWrite/RegWrite drop in the same instant, no partial writeback.
- Illegal state codes (17..31): next state RST, outputs 0.

Optional Feature:
- Macro: OVF_TRAP_EN.
- Defined:
  - In WBR for add/sub and in WBI: overflow=1 forces RegWrite=0, next state EXC.
  - and never traps.
- Undefined: overflow is ignored; WBR/WBI always write and return to F0. Port remains present but unused.

Test Plan:
- Reset held low 3 cycles, release → all outputs 0, state=0, then state 1 on next edge, IRWrite=1 in state 3 with PCWrite=1, PCSource=0.
- opcode=0x00 funct=0x22 → after DEC: ALUOp=010 in EXR, RegWrite=1 RegDst=1 in WBR, back to F0; 7 cycles F0→F0.
- opcode=0x23 → MA (ALUSrcB=2), MR0 IorD=1, one MRW, MWB MemToReg=1 RegWrite=1; 9 cycles total. opcode=0x2B → MemWrite high exactly 1 cycle with IorD=1.
- opcode=0x04: zero=1 → PCWrite=1, PCSource=1 in BR; zero=0 → PCWrite=0 in BR; both return to F0.
- opcode=0x3F or opcode=0x00 funct=0x27 → EXC: PCSource=3, PCWrite=1, EPCWrite=1, then F0.
- OVF_TRAP_EN, addi with overflow=1 in WBI → RegWrite=0, next EXC. Without macro → RegWrite=1, next F0. Reset asserted during MW → MemWrite=0 immediately.
